// File: rtl/crc32_stream.sv
// Multi-byte-per-beat reflected CRC-32 engine with start/last framing,
// partial last beat via keep, and a result held until acknowledged.
module crc32_stream #(
   parameter int          DATA_BYTES = 4,
   parameter logic [31:0] POLY_REFL  = 32'hEDB88320,
   parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
   parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    crc32_valid_in,
   output logic                    crc32_ready_out,
   input  logic                    crc32_start_in,
   input  logic                    crc32_last_in,
   input  logic [DATA_BYTES-1:0]   crc32_keep_in,
   input  logic [8*DATA_BYTES-1:0] crc32_in,
   output logic                    crc32_valid_out,
   output logic [31:0]             crc32_out,
   input  logic                    crc32_ack_in,
   output logic                    crc32_err_out
);

   localparam int DATA_W = 8 * DATA_BYTES;
   localparam int CNT_W  = $clog2(DATA_BYTES + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [31:0]      crc_q;
   logic             accept;
   logic             fold_en;
   logic             frame_err;
   logic [CNT_W-1:0] nbytes;
   logic [31:0]      crc_base;
   logic [31:0]      crc_next;

   // Bytes ascending from byte 0, bits LSB-first within each byte.
   function automatic logic [31:0] crc_fold(input logic [31:0]      crc,
                                            input logic [DATA_W-1:0] data,
                                            input logic [CNT_W-1:0]  cnt);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i < int'(cnt)) begin
            c = c ^ {24'd0, data[8*i +: 8]};
            for (int b = 0; b < 8; b++)
               c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
         end
      end
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] keep_count(input logic [DATA_BYTES-1:0] keep);
      int  n;
      logic run;
      n   = 0;
      run = 1'b1;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (run && keep[i]) n++;
         else run = 1'b0;
      end
      return CNT_W'(n);
   endfunction

   // A set bit above the first clear bit marks a non-contiguous mask.
   function automatic logic keep_gap(input logic [DATA_BYTES-1:0] keep);
      logic seen_zero;
      logic gap;
      seen_zero = 1'b0;
      gap       = 1'b0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (!keep[i]) seen_zero = 1'b1;
         else if (seen_zero) gap = 1'b1;
      end
      return gap;
   endfunction

   assign crc32_ready_out = !crc32_valid_out || crc32_ack_in;

   always_comb begin
      accept    = crc32_valid_in && crc32_ready_out;
      fold_en   = accept && (crc32_start_in || (state_q == RUN));
      frame_err = accept && ((!crc32_start_in && (state_q == IDLE)) ||
                             (crc32_start_in && (state_q == RUN)) ||
                             (crc32_last_in && keep_gap(crc32_keep_in)));
      nbytes    = crc32_last_in ? keep_count(crc32_keep_in) : CNT_W'(DATA_BYTES);
      crc_base  = crc32_start_in ? CRC_INIT : crc_q;
      crc_next  = crc_fold(crc_base, crc32_in, nbytes);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         crc_q           <= CRC_INIT;
         crc32_out       <= '0;
         crc32_valid_out <= 1'b0;
         crc32_err_out   <= 1'b0;
      end else begin
         crc32_err_out <= frame_err;
         if (fold_en) begin
            crc_q   <= crc_next;
            state_q <= crc32_last_in ? IDLE : RUN;
         end
         // A finalise on the ack edge replaces the old result and keeps valid high.
         if (fold_en && crc32_last_in) begin
            crc32_out       <= crc_next ^ XOR_OUT;
            crc32_valid_out <= 1'b1;
         end else if (crc32_ack_in && crc32_valid_out) begin
            crc32_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: a 1-byte instance and a 4-byte instance
// driven with known CRC-32 check vectors, framing errors, stalls and reset.
module tb_crc32_stream;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        v4 = 0, s4 = 0, l4 = 0, ack4 = 0;
   logic [3:0]  k4 = '0;
   logic [31:0] d4 = '0;
   logic        rdy4, vo4, err4;
   logic [31:0] out4;

   logic        v1 = 0, s1 = 0, l1 = 0, ack1 = 0;
   logic [0:0]  k1 = '0;
   logic [7:0]  d1 = '0;
   logic        rdy1, vo1, err1;
   logic [31:0] out1;

   crc32_stream #(.DATA_BYTES(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .crc32_valid_in(v4), .crc32_ready_out(rdy4),
      .crc32_start_in(s4), .crc32_last_in(l4),
      .crc32_keep_in(k4), .crc32_in(d4),
      .crc32_valid_out(vo4), .crc32_out(out4),
      .crc32_ack_in(ack4), .crc32_err_out(err4)
   );

   crc32_stream #(.DATA_BYTES(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .crc32_valid_in(v1), .crc32_ready_out(rdy1),
      .crc32_start_in(s1), .crc32_last_in(l1),
      .crc32_keep_in(k1), .crc32_in(d1),
      .crc32_valid_out(vo1), .crc32_out(out1),
      .crc32_ack_in(ack1), .crc32_err_out(err1)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int err_cnt4 = 0;
   int err_cnt1 = 0;
   int e0;
   logic [7:0] q[$];

   always @(negedge clk) begin
      if (err4 === 1'b1) err_cnt4++;
      if (err1 === 1'b1) err_cnt1++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one beat, wait (bounded) for ready, then complete it on the next edge.
   task automatic beat4(input logic s, input logic l, input logic [3:0] k, input logic [31:0] d);
      int n;
      v4 = 1'b1; s4 = s; l4 = l; k4 = k; d4 = d;
      n = 0;
      while (rdy4 !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("beat4_ready", 32'(rdy4), 32'd1);
      @(posedge clk); #1;
      v4 = 1'b0;
   endtask

   task automatic beat1(input logic s, input logic l, input logic [7:0] d);
      v1 = 1'b1; s1 = s; l1 = l; k1 = 1'b1; d1 = d;
      @(posedge clk); #1;
      v1 = 1'b0;
   endtask

   task automatic load_str(input string str);
      q.delete();
      for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
   endtask

   // Sends q as one message on the 4-byte instance and checks the result.
   task automatic send_q(input logic [31:0] exp, input string tag);
      logic [31:0] d;
      logic [3:0]  k;
      for (int i = 0; i < q.size(); i += 4) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 4; j++) begin
            if (i + j < q.size()) begin
               d[8*j +: 8] = q[i+j];
               k[j] = 1'b1;
            end
         end
         beat4(i == 0, i + 4 >= q.size(), k, d);
      end
      chk({tag, "_valid"}, 32'(vo4), 32'd1);
      chk(tag, out4, exp);
   endtask

   task automatic idle_cycle;
      @(posedge clk); #1;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_valid", 32'(vo4), 32'd0);
      chk("rst_out", out4, 32'h0);
      chk("rst_err", 32'(err4), 32'd0);
      chk("rst_ready", 32'(rdy4), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycle();

      // One byte per beat: "0123456789".
      load_str("0123456789");
      for (int i = 0; i < 9; i++) beat1(i == 0, 1'b0, q[i]);
      chk("b1_not_yet_valid", 32'(vo1), 32'd0);
      beat1(1'b0, 1'b1, q[9]);
      chk("b1_valid", 32'(vo1), 32'd1);
      chk("b1_digits", out1, 32'hA684C7C6);
      idle_cycle();
      chk("b1_hold", out1, 32'hA684C7C6);
      ack1 = 1'b1;
      idle_cycle();
      chk("b1_ack_clears", 32'(vo1), 32'd0);
      ack1 = 1'b0;

      // Four bytes per beat, three messages back to back.
      ack4 = 1'b1;
      e0 = err_cnt4;
      q.delete();
      for (int i = 0; i < 32; i++) q.push_back(8'h00);
      send_q(32'h190A55AD, "zeros32");
      q.delete();
      for (int i = 0; i < 32; i++) q.push_back(8'hFF);
      send_q(32'hFF6CAB0B, "ones32");
      q.delete();
      for (int i = 0; i < 32; i++) q.push_back(8'(i));
      send_q(32'h91267E8A, "ramp32");
      idle_cycle();
      chk("clean_no_err", 32'(err_cnt4 - e0), 32'd0);

      load_str("The quick brown fox jumps over the lazy dog");
      send_q(32'h414FA339, "fox_keep0111");
      load_str("123456789");
      send_q(32'hCBF43926, "check_keep0001");

      // keep == 0 together with start gives CRC_INIT ^ XOR_OUT.
      beat4(1'b1, 1'b1, 4'b0000, 32'hDEADBEEF);
      chk("keep0_start", out4, 32'h00000000);

      // Result pending with no ack stalls the next message's last beat.
      idle_cycle();
      ack4 = 1'b0;
      load_str("123456789");
      send_q(32'hCBF43926, "stall_first");
      v4 = 1'b1; s4 = 1'b1; l4 = 1'b1; k4 = 4'b0111; d4 = 32'h00636261;
      #1;
      chk("stall_ready_low", 32'(rdy4), 32'd0);
      @(posedge clk); #1;
      chk("stall_out_held", out4, 32'hCBF43926);
      chk("stall_valid_held", 32'(vo4), 32'd1);
      ack4 = 1'b1;
      #1;
      chk("stall_ready_ack", 32'(rdy4), 32'd1);
      @(posedge clk); #1;
      v4 = 1'b0;
      chk("stall_new_valid", 32'(vo4), 32'd1);
      chk("stall_new_abc", out4, 32'h352441C2);
      idle_cycle();
      chk("stall_ack_clears", 32'(vo4), 32'd0);

      // Beat without start while idle.
      e0 = err_cnt4;
      beat4(1'b0, 1'b0, 4'b1111, 32'h33323130);
      chk("nostart_err_now", 32'(err4), 32'd1);
      idle_cycle();
      chk("nostart_err_one_cycle", 32'(err4), 32'd0);
      load_str("0123456789");
      send_q(32'hA684C7C6, "after_nostart");
      idle_cycle();
      chk("nostart_err_count", 32'(err_cnt4 - e0), 32'd1);

      // Start while a message is open.
      e0 = err_cnt4;
      beat4(1'b1, 1'b0, 4'b1111, 32'h7A7A7A7A);
      load_str("123456789");
      send_q(32'hCBF43926, "restart_new_only");
      idle_cycle();
      chk("restart_err_count", 32'(err_cnt4 - e0), 32'd1);

      // Non-contiguous keep folds only the leading byte ("1").
      e0 = err_cnt4;
      beat4(1'b1, 1'b1, 4'b0101, 32'h43424131);
      chk("gap_one_byte", out4, 32'h83DCEFB7);
      idle_cycle();
      chk("gap_err_count", 32'(err_cnt4 - e0), 32'd1);

      // Asynchronous reset while a result and an err pulse are pending.
      beat4(1'b1, 1'b0, 4'b1111, 32'h61616161);
      beat4(1'b1, 1'b1, 4'b0000, 32'h0);
      chk("pre_rst_err", 32'(err4), 32'd1);
      chk("pre_rst_valid", 32'(vo4), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(vo4), 32'd0);
      chk("async_rst_err", 32'(err4), 32'd0);
      chk("async_rst_ready", 32'(rdy4), 32'd1);
      chk("async_rst_out1", out1, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      beat4(1'b1, 1'b0, 4'b1111, 32'h61626364);
      rst = 1'b1;
      #1;
      chk("midmsg_rst_valid", 32'(vo4), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      load_str("0123456789");
      send_q(32'hA684C7C6, "after_reset");
      idle_cycle();
      chk("b1_never_err", 32'(err_cnt1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/crc32_stream.md
# crc32_stream

Parametrised, multi-byte-per-cycle CRC-32 engine for the GZIP trailer path and any other framed byte stream. It generalises the single-byte CRC32 block: it accepts up to DATA_BYTES bytes per beat, supports explicit start and last framing with a partial last beat, and holds each result until the consumer acknowledges it. Back-to-back messages need no reset in between. It sits between the literal/byte stream source and the GZIP footer writer.

## Interface
- DATA_BYTES, 4 — bytes per beat; legal values are 1, 2, 4, 8.
- POLY_REFL, 32'hEDB88320 — reflected generator polynomial.
- CRC_INIT, 32'hFFFFFFFF — register value loaded at message start.
- XOR_OUT, 32'hFFFFFFFF — value XORed onto the register to form the result.

- clk  in  1  — single clock; all state changes on the rising edge.
- rst  in  1  — asynchronous, active-high reset.
- crc32_valid_in  in  1  — beat present.
- crc32_ready_out  out  1  — beat accepted when valid_in && ready_out.
- crc32_start_in  in  1  — first beat of a message.
- crc32_last_in  in  1  — final beat of a message.
- crc32_keep_in  in  DATA_BYTES  — byte enables; honoured on the last beat only.
- crc32_in  in  8*DATA_BYTES  — data; byte 0 = [7:0] is processed first.
- crc32_valid_out  out  1  — final CRC pending.
- crc32_out  out  32  — final CRC, already XORed with XOR_OUT.
- crc32_ack_in  in  1  — consumer takes the result.
- crc32_err_out  out  1  — one-cycle framing-error pulse.

## Operation
- Bits are processed LSB-first within each byte (reflected, gzip/zlib CRC-32). Bytes are processed ascending from byte 0.
- Per-beat update is a combinational unrolled loop over DATA_BYTES bytes, 8 bits each. The running register crc_q is 32 bits.
- Frame FSM has two states: IDLE (no message open) and RUN.
  - IDLE, accepted beat with start=1: seed crc_q with CRC_INIT and fold the beat. If last=1, finalise and stay in IDLE; otherwise go to RUN.
  - IDLE, accepted beat with start=0: drop the beat, pulse err, stay in IDLE.
  - RUN, accepted beat with start=0: fold the beat. If last=1, finalise and go to IDLE.
  - RUN, accepted beat with start=1: abandon the open message, pulse err, then treat the beat as a fresh start beat (same rules as IDLE).
- Beats that are not last use all bytes; keep_in is ignored on them.
- Last-beat keep handling:
  - The number of bytes folded is the count of contiguous ones from bit 0.
  - keep == 0 folds no data; the result is ~CRC of the bytes so far. With start=1 as well, the result is CRC_INIT ^ XOR_OUT, which is 32'h00000000 with the default parameters.
  - A non-contiguous mask (a 1 above the first 0) pulses err and still uses the contiguous count.
- Finalise: crc32_out <= fold(crc_q, beat) ^ XOR_OUT, and valid_out <= 1.
- Result holding: crc32_out and valid_out hold until ack_in is sampled high while valid_out=1. On that edge valid_out clears, unless a new finalise happens on the same edge; the new result then loads and valid_out stays 1.
- crc32_ready_out = !crc32_valid_out || crc32_ack_in. Input stalls only while a result is pending and not being acknowledged.
- crc_q is ignored while in IDLE.

## Timing
- Reset values (asynchronous, while rst=1): state=IDLE, crc_q=CRC_INIT, crc32_out=0, valid_out=0, err_out=0. ready_out=1 follows combinationally.
- Reset mid-message discards the open message and any pending result. No err pulse.
- Latency: a last beat accepted at edge N shows valid_out=1 and the final CRC after edge N (visible in cycle N+1).
- Throughput: one beat per cycle, with zero gap between messages (last at N, start at N+1).
- err_out is registered: high for exactly the one cycle after the offending edge.
- ack_in while valid_out=0 is ignored.
- valid_in low: no state change, except result ack handling.

## Test plan
- DATA_BYTES=1, "0123456789" as 10 beats, start on the first and last on the tenth -> valid_out one cycle after the last beat, crc32_out=32'hA684C7C6. Ack clears valid_out.
- DATA_BYTES=4:
  - 32 bytes of 8'h00 (8 full beats) -> 32'h190A55AD.
  - Immediately after, with no reset and no gap, 32 bytes of 8'hFF -> 32'hFF6CAB0B.
  - Then 00..1F -> 32'h91267E8A.
- DATA_BYTES=4, "The quick brown fox jumps over the lazy dog" (43 bytes), last beat keep=4'b0111 -> 32'h414FA339. Also "123456789" with last keep=4'b0001 -> 32'hCBF43926.
- Hold ack_in low after a result and present the next message's last beat -> ready_out=0 and the beat is stalled; crc32_out is unchanged. Raise ack -> the beat is accepted on the same edge and the new result appears the next cycle.
- Framing errors:
  - Beat without start in IDLE -> one err pulse; the following correct "0123456789" message still gives 32'hA684C7C6.
  - Start mid-message -> err pulse; the result covers the new message only.
  - keep=4'b0101 -> err pulse; the result covers one byte.
- Assert rst for 1 cycle mid-message -> all outputs return to their reset values asynchronously. A fresh "0123456789" message then gives 32'hA684C7C6.
